// File: rtl/disk_host_arbiter.sv
// Round-robin arbiter sharing one host disk service channel between two
// disk_sr/disk_cr requesters, with a watchdog that synthesises an error completion.
module disk_host_arbiter #(
    parameter int          TW      = 24,
    parameter logic [TW-1:0] TIMEOUT = 24'd16000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req0_sr,
    output logic [31:0] req0_cr,
    output logic [7:0]  req0_data_in,
    output logic        req0_data_clkin,
    input  logic [7:0]  req0_data_out,
    output logic        req0_data_clkout,
    input  logic [31:0] req1_sr,
    output logic [31:0] req1_cr,
    output logic [7:0]  req1_data_in,
    output logic        req1_data_clkin,
    input  logic [7:0]  req1_data_out,
    output logic        req1_data_clkout,
    output logic [31:0] host_sr,
    input  logic [31:0] host_cr,
    input  logic [7:0]  host_data_in,
    input  logic        host_data_clkin,
    output logic [7:0]  host_data_out,
    input  logic        host_data_clkout,
    output logic        busy,
    output logic        owner,
    output logic        timeout_pulse
);
    typedef enum logic [2:0] {IDLE, GRANT, RESP, RELEASE, TOUT} state_t;

    localparam logic [TW-1:0] TMAX = TIMEOUT - 1'b1;

    function automatic logic [7:0] cmd_of(input logic [31:0] s);
        return {s[25:24], s[23:22], s[21:20], s[18:17]};
    endfunction

    state_t          state;
    logic            last_grant;
    logic [TW-1:0]   timer;
    logic [1:0][31:0] sr;
    logic [1:0][7:0]  dout;
    logic [1:0]      pend;
    logic [31:0]     owner_sr;
    logic            owner_pend;
    logic            host_done;
    logic            grant_idx;
    logic            route;

    assign sr         = {req1_sr, req0_sr};
    assign dout       = {req1_data_out, req0_data_out};
    assign pend       = {|cmd_of(req1_sr), |cmd_of(req0_sr)};
    assign owner_sr   = sr[owner];
    assign owner_pend = |cmd_of(owner_sr);
    assign host_done  = host_cr[4] | host_cr[1] | host_cr[0];
    // On a tie the side that did not win last time gets the channel.
    assign grant_idx  = (&pend) ? ~last_grant : pend[1];
    assign busy       = (state != IDLE);
    assign route      = (state == GRANT) || (state == RESP) || (state == RELEASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_grant    <= 1'b1;
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (|pend) begin
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (timer != TMAX)
                        timer <= timer + 1'b1;
                    if (host_done)
                        state <= RESP;
                    else if (!owner_pend)
                        state <= RELEASE;
                    else if (timer == TMAX) begin
                        state         <= TOUT;
                        timeout_pulse <= 1'b1;
                    end
                end
                RESP:    if (!owner_pend) state <= RELEASE;
                RELEASE: if (!host_done)  state <= IDLE;
                TOUT:    if (!owner_pend) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [1:0][31:0] cr;
    logic [1:0]       clkin, clkout;
    logic [7:0]       din;

    always_comb begin
        cr            = '0;
        clkin         = '0;
        clkout        = '0;
        din           = '0;
        host_sr       = '0;
        host_data_out = '0;
        if (route) begin
            host_sr        = owner_sr;
            cr[owner]      = host_cr;
            din            = host_data_in;
            clkin[owner]   = host_data_clkin;
            clkout[owner]  = host_data_clkout;
            host_data_out  = dout[owner];
        end else if (state == TOUT) begin
            // done + error, seek-done bits echo the seek the requester asked for
            cr[owner] = {27'h0, 1'b1, 1'b1, 1'b0, owner_sr[25:24]};
        end
    end

    assign req0_cr          = cr[0];
    assign req1_cr          = cr[1];
    assign req0_data_in     = din;
    assign req1_data_in     = din;
    assign req0_data_clkin  = clkin[0];
    assign req1_data_clkin  = clkin[1];
    assign req0_data_clkout = clkout[0];
    assign req1_data_clkout = clkout[1];
endmodule

// File: tb/tb_disk_host_arbiter.sv
// Scenario bench for disk_host_arbiter; expected values queued at stimulus time
// and popped when the DUT reaches the matching point.
module tb_disk_host_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req0_sr, req1_sr, req0_cr, req1_cr, host_sr, host_cr;
    logic [7:0]  req0_data_in, req1_data_in, req0_data_out, req1_data_out;
    logic [7:0]  host_data_in, host_data_out;
    logic        req0_data_clkin, req1_data_clkin, req0_data_clkout, req1_data_clkout;
    logic        host_data_clkin, host_data_clkout, busy, owner, timeout_pulse;

    disk_host_arbiter #(.TW(24), .TIMEOUT(24'd100)) dut (
        .clk(clk), .reset(reset),
        .req0_sr(req0_sr), .req0_cr(req0_cr), .req0_data_in(req0_data_in),
        .req0_data_clkin(req0_data_clkin), .req0_data_out(req0_data_out),
        .req0_data_clkout(req0_data_clkout),
        .req1_sr(req1_sr), .req1_cr(req1_cr), .req1_data_in(req1_data_in),
        .req1_data_clkin(req1_data_clkin), .req1_data_out(req1_data_out),
        .req1_data_clkout(req1_data_clkout),
        .host_sr(host_sr), .host_cr(host_cr), .host_data_in(host_data_in),
        .host_data_clkin(host_data_clkin), .host_data_out(host_data_out),
        .host_data_clkout(host_data_clkout),
        .busy(busy), .owner(owner), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic set_sr(input int idx, input logic [31:0] v);
        if (idx == 0) req0_sr = v; else req1_sr = v;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req0_sr = '0; req1_sr = '0; host_cr = '0;
        req0_data_out = '0; req1_data_out = '0; host_data_in = '0;
        host_data_clkin = 1'b0; host_data_clkout = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        @(negedge clk);
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!busy) begin
            errors++;
            $display("FAIL %s_grant busy=%0b required 1 within 20 cycles", tag, busy);
        end
    endtask

    task automatic check_owner(input string tag);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        if ({31'h0, owner} !== e) begin
            errors++;
            $display("FAIL %s_owner got %0d required %0d", tag, owner, e);
        end
    endtask

    // Owner finishes normally: host done, ack-of-ack, host clears, then new_sr.
    task automatic complete(input int idx, input logic [31:0] new_sr);
        host_cr = 32'h10;
        tick;
        set_sr(idx, 32'h0001_0000);
        tick;
        host_cr = '0;
        tick;
        set_sr(idx, new_sr);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req0_sr = 32'h0002_0000; req1_sr = 32'h0002_0000; host_cr = 32'h13;
        host_data_clkin = 1'b1; host_data_clkout = 1'b1;
        host_data_in = 8'hA5; req0_data_out = 8'h5A; req1_data_out = 8'h3C;
        tick;
        @(negedge clk);
        checks++;
        if ({host_sr, req0_cr, req1_cr, busy, owner, timeout_pulse,
             req0_data_clkin, req1_data_clkin, req0_data_clkout, req1_data_clkout,
             host_data_out, req0_data_in, req1_data_in} !== '0) begin
            errors++;
            $display("FAIL reset_outputs host_sr=%h cr0=%h cr1=%h busy=%0b owner=%0b tp=%0b dout=%h required all 0",
                     host_sr, req0_cr, req1_cr, busy, owner, timeout_pulse, host_data_out);
        end
        do_reset;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || host_sr !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle busy=%0b host_sr=%h required 0/0", busy, host_sr);
        end
    endtask

    task automatic test_single_read;
        req0_sr = 32'h0002_0142;
        exp_q.push_back(32'h0002_0142);
        wait_busy("read");
        checks++;
        if (host_sr !== exp_q[0]) begin
            errors++;
            $display("FAIL read_host_sr got %h required %h", host_sr, exp_q[0]);
        end
        void'(exp_q.pop_front());
        host_cr = 32'h0000_0010;
        tick;
        @(negedge clk);
        checks++;
        if (req0_cr !== 32'h10 || req1_cr !== 32'h0) begin
            errors++;
            $display("FAIL read_cr cr0=%h cr1=%h required 10/0", req0_cr, req1_cr);
        end
        req0_sr = 32'h0001_0142;
        tick;
        @(negedge clk);
        checks++;
        if (host_sr[16] !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL read_ackack host_sr=%h busy=%0b required bit16=1 busy=1", host_sr, busy);
        end
        host_cr = '0;
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || host_sr !== 32'h0) begin
            errors++;
            $display("FAIL read_release busy=%0b host_sr=%h required 0/0", busy, host_sr);
        end
        req0_sr = '0;
    endtask

    task automatic test_simultaneous;
        int viol = 0;
        int seen = 0;
        do_reset;
        req0_sr = 32'h0100_0000;
        req1_sr = 32'h0002_0000;
        exp_q.push_back(0);
        exp_q.push_back(1);
        wait_busy("simul0");
        check_owner("simul0");
        host_cr = 32'h0000_0100;
        for (int i = 0; i < 4; i++) begin
            host_data_clkin = 1'b1; host_data_clkout = 1'b1;
            @(negedge clk);
            if (req1_cr !== 32'h0 || req1_data_clkin || req1_data_clkout) viol++;
            if (req0_data_clkin && req0_data_clkout && req0_cr == 32'h100) seen++;
            tick;
            host_data_clkin = 1'b0; host_data_clkout = 1'b0;
        end
        checks++;
        if (viol != 0 || seen != 4) begin
            errors++;
            $display("FAIL simul_isolation leaks=%0d owner_strobes=%0d required 0/4", viol, seen);
        end
        complete(0, 32'h0);
        wait_busy("simul1");
        check_owner("simul1");
        complete(1, 32'h0);
    endtask

    task automatic test_fairness;
        do_reset;
        req0_sr = 32'h0002_0000;
        req1_sr = 32'h0002_0000;
        for (int k = 0; k < 4; k++) exp_q.push_back(k % 2);
        for (int k = 0; k < 4; k++) begin
            int o;
            wait_busy("fair");
            o = owner;
            check_owner($sformatf("fair%0d", k));
            if (k == 3) begin
                complete(o, 32'h0);
                req0_sr = '0; req1_sr = '0;
            end else begin
                complete(o, 32'h0002_0000);
            end
        end
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL fair_idle busy=%0b required 0", busy);
        end
    endtask

    task automatic test_data_gating;
        int c1 = 0, c0 = 0, bad = 0;
        req1_sr = 32'h0002_0000;
        exp_q.push_back(1);
        wait_busy("gate");
        check_owner("gate");
        host_cr = 32'h10;
        tick;
        for (int i = 0; i < 512; i++) begin
            host_data_clkin = 1'b1; host_data_clkout = 1'b1;
            host_data_in = i[7:0];
            req1_data_out = 8'($urandom);
            req0_data_out = ~req1_data_out;
            @(negedge clk);
            if (req1_data_clkin) c1++;
            if (req0_data_clkin || req0_data_clkout) c0++;
            if (host_data_out !== req1_data_out || req1_data_in !== i[7:0]) bad++;
            tick;
            host_data_clkin = 1'b0; host_data_clkout = 1'b0;
            @(negedge clk);
            if (req1_data_clkin) c1++;
            if (req0_data_clkin || req0_data_clkout) c0++;
            tick;
        end
        checks++;
        if (c1 != 512) begin
            errors++;
            $display("FAIL gate_owner_pulses got %0d required 512", c1);
        end
        checks++;
        if (c0 != 0) begin
            errors++;
            $display("FAIL gate_nonowner_pulses got %0d required 0", c0);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gate_data mismatches %0d required 0", bad);
        end
        req1_sr = 32'h0001_0000;
        tick;
        host_cr = '0;
        tick;
        req1_sr = '0;
    endtask

    task automatic test_timeout;
        int cnt = 0, n = 0;
        req1_sr = 32'h0200_0000;
        exp_q.push_back(32'h0000_001A);
        wait_busy("tout");
        while (!timeout_pulse && n < 300) begin
            if (host_sr != 32'h0) cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!timeout_pulse || cnt != 100) begin
            errors++;
            $display("FAIL tout_cycles pulse=%0b grant_cycles=%0d required 1/100", timeout_pulse, cnt);
        end
        checks++;
        if (req1_cr !== exp_q[0] || req0_cr !== 32'h0 || host_sr !== 32'h0) begin
            errors++;
            $display("FAIL tout_cr cr1=%h cr0=%h host_sr=%h required %h/0/0", req1_cr, req0_cr, host_sr, exp_q[0]);
        end
        void'(exp_q.pop_front());
        @(negedge clk);
        checks++;
        if (timeout_pulse !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL tout_hold pulse=%0b busy=%0b required 0/1", timeout_pulse, busy);
        end
        req1_sr = '0;
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tout_idle busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_and_abort;
        do_reset;
        req0_sr = 32'h0002_0000;
        wait_busy("midrst");
        host_cr = 32'h0000_0100;
        host_data_clkin = 1'b1;
        #1;
        checks++;
        if (req0_cr !== 32'h100 || req0_data_clkin !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre cr0=%h clkin0=%0b required 100/1", req0_cr, req0_data_clkin);
        end
        reset = 1'b1;
        tick;
        @(negedge clk);
        checks++;
        if ({host_sr, req0_cr, req1_cr, busy, owner, timeout_pulse, req0_data_clkin} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs host_sr=%h cr0=%h busy=%0b clkin0=%0b required 0",
                     host_sr, req0_cr, busy, req0_data_clkin);
        end
        do_reset;
        req0_sr = 32'h0002_0000;
        wait_busy("abort");
        req0_sr = '0;
        tick;
        host_cr = 32'h02;
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || req0_cr !== 32'h02) begin
            errors++;
            $display("FAIL abort_release busy=%0b cr0=%h required 1/02", busy, req0_cr);
        end
        host_cr = '0;
        tick;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle busy=%0b required 0", busy);
        end
    endtask

    initial begin
        do_reset;
        test_reset;
        test_single_read;
        test_simultaneous;
        test_fairness;
        test_data_gating;
        test_timeout;
        test_reset_mid_and_abort;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
